// File: rtl/fsm_sensor_pkg.sv
// fsm_sensor_pkg: shared types and constants for the sensor conditioning stage
package fsm_sensor_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        PEND_HI = 2'd1,
        ST_HI   = 2'd2,
        PEND_LO = 2'd3
    } deb_state_t;

    localparam int CH_BUMPER = 0;
    localparam int CH_DIRT   = 1;
    localparam int CH_CLIFF  = 2;
    localparam int CH_BATT   = 3;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/fsm_sensor_conditioner_debounce_ch.sv
// fsm_sensor_debounce_ch: 2-flop synchroniser plus counter-based debounce FSM for one sensor channel
module fsm_sensor_debounce_ch
    import fsm_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, rise_q, fall_q;
    logic             sync, cur, flip;

    assign sync = sync_q[1];

    // A sample equal to the current level cancels any pending change; a differing
    // sample either extends the run or, on its last required sample, flips the level.
    always_comb begin
        cur     = state_q == ST_HI || state_q == PEND_LO;
        flip    = sample_en && sync != cur && cnt_q == LAST;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_en) begin
            state_d = sync == cur ? (cur ? ST_HI : ST_LO)
                    : flip        ? (cur ? ST_LO : ST_HI)
                    :               (cur ? PEND_LO : PEND_HI);
            cnt_d   = (sync == cur || flip) ? '0 : cnt_q + 1'b1;
        end
    end

    // Synchroniser, FSM state and registered level/edge outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= cur ^ flip;
            rise_q  <= flip && !cur;
            fall_q  <= flip && cur;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/fsm_sensor_conditioner.sv
// fsm_sensor_conditioner: synchronises and debounces raw sensor pins into clean levels and edge pulses
// Build option: define SENSOR_STICKY_EN to make event_o a sticky rise flag cleared by clr_i.
module fsm_sensor_conditioner
    import fsm_sensor_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [NUM_CH-1:0] raw_i,
    input  logic [NUM_CH-1:0] clr_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] event_o
);

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        fsm_sensor_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_en(sample_en),
            .raw_i    (raw_i[i]),
            .level_o  (level_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

`ifdef SENSOR_STICKY_EN
    logic [NUM_CH-1:0] event_q;

    // Set on a rise, held until cleared; a simultaneous rise beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) event_q <= '0;
        else        event_q <= rise_o | (event_q & ~clr_i);
    end

    assign event_o = event_q;
`else
    logic unused_clr;

    assign unused_clr = ^clr_i;
    assign event_o    = rise_o;
`endif

endmodule

// File: tb/tb_fsm_sensor_conditioner.sv
// tb_fsm_sensor_conditioner: scoreboard bench with a run-length reference model of the debouncer
module tb_fsm_sensor_conditioner;

    localparam int N = 4;
    localparam int D = 4;
`ifdef SENSOR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_en = 1'b0;
    logic [N-1:0] raw_i = '0;
    logic [N-1:0] clr_i = '0;
    logic [N-1:0] level_o, rise_o, fall_o, event_o;

    fsm_sensor_conditioner #(.NUM_CH(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(sample_en),
        .raw_i    (raw_i),
        .clr_i    (clr_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .event_o  (event_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] ev;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0, m_fall = '0, m_ev = '0;
    int           m_run[N];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // Level flips once the synchronised pin has differed from it on D consecutive sampled edges
    task automatic model_step();
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_ev = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                if (sample_en) begin
                    if (m_s2[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == D) begin
                            m_lvl[c] = ~m_lvl[c];
                            m_run[c] = 0;
                            if (m_lvl[c]) m_rise[c] = 1'b1;
                            else          m_fall[c] = 1'b1;
                        end
                    end else m_run[c] = 0;
                end
            end
            m_ev = STICKY ? (m_rise | (m_ev & ~clr_i)) : m_rise;
            m_s2 = m_s1;
            m_s1 = raw_i;
        end
        q.push_back('{m_lvl, m_rise, m_fall, m_ev});
    endtask

    // Monitor: every clock the DUT presents a fresh output set; compare with the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("level", level_o, e.lvl);
                chk("rise",  rise_o,  e.rise);
                chk("fall",  fall_o,  e.fall);
                chk("event", event_o, e.ev);
            end
        end
    end

    task automatic cyc(logic [N-1:0] raw, logic se, logic [N-1:0] clr, logic rst);
        logic prev;
        @(posedge clk);
        #2;
        prev      = rst_n;
        raw_i     = raw;
        sample_en = se;
        clr_i     = clr;
        rst_n     = rst;
        model_step();
        if (prev && !rst) begin
            #1;
            chk("rst_level", level_o, 0);
            chk("rst_rise",  rise_o,  0);
            chk("rst_fall",  fall_o,  0);
            chk("rst_event", event_o, 0);
        end
    endtask

    task automatic measure(string nm, int ch, logic tgt, logic [N-1:0] raw, bit alt, int exp_lat);
        int lat = 0;
        cyc(raw, !alt, '0, 1'b1);
        while (level_o[ch] !== tgt && lat < 40) begin
            lat++;
            cyc(raw, alt ? lat[0] : 1'b1, '0, 1'b1);
        end
        chk(nm, lat, exp_lat);
    endtask

    initial begin
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) m_run[c] = 0;
        repeat (3) cyc('0, 1'b1, '0, 1'b0);
        repeat (20) cyc('0, 1'b1, '0, 1'b1);
        chk("idle_level", level_o, 0);

        measure("ch0_rise_latency", 0, 1'b1, 4'b0001, 1'b0, 6);
        repeat (3) cyc(4'b0001, 1'b1, '0, 1'b1);
        chk("ch0_only_level", level_o, 4'b0001);

        repeat (3) cyc(4'b0011, 1'b1, '0, 1'b1);
        cyc(4'b0001, 1'b1, '0, 1'b1);
        chk("bounce_no_rise", level_o[1], 0);
        measure("ch1_rise_after_bounce", 1, 1'b1, 4'b0011, 1'b0, 6);

        measure("ch2_rise_half_rate", 2, 1'b1, 4'b0111, 1'b1, 10);
        measure("ch2_fall_half_rate", 2, 1'b0, 4'b0011, 1'b1, 10);

        repeat (12) cyc('0, 1'b1, '0, 1'b1);
        repeat (5) cyc(4'b0001, 1'b1, '0, 1'b1);
        repeat (2) cyc(4'b0001, 1'b1, '0, 1'b0);
        measure("rise_after_reset", 0, 1'b1, 4'b0001, 1'b0, 6);

        measure("ch3_rise", 3, 1'b1, 4'b1001, 1'b0, 6);
        repeat (3) cyc(4'b1001, 1'b1, '0, 1'b1);
        chk("ch3_event_hold", event_o[3], STICKY);
        cyc(4'b1001, 1'b1, 4'b1000, 1'b1);
        cyc(4'b1001, 1'b1, '0, 1'b1);
        chk("ch3_event_cleared", event_o[3], 0);

        r = 4'b1001;
        repeat (600) begin
            for (int c = 0; c < N; c++) if ($urandom_range(7) == 0) r[c] = ~r[c];
            cyc(r, $urandom_range(3) != 0, N'($urandom), $urandom_range(99) != 0);
        end
        repeat (40) cyc(r, 1'b1, N'($urandom), 1'b1);

        repeat (2) @(posedge clk);
        #3;
        if (q.size() != 0) chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
